// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// It stalls the front of the pipeline while it works, then presents the result
// and destination in DONE until the EX/MEM register accepts them.
// Optional macro MULDIV_FAST_MUL_EN: the four multiply ops finish in one cycle
// using a combinational 33x33 signed product. Divides always iterate.
module ex_muldiv #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [4:0]      dest_i,
    input  logic            squash_i,
    input  logic            hold_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      dest_o
);

    localparam int unsigned CALC_LEN = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W    = $clog2(CALC_LEN);
    localparam int unsigned DW       = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        dest_q, dest_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_q, neg_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              s1_signed, s2_signed, s1_neg, s2_neg, is_div_i, div_ovf;
    logic [XLEN-1:0]   mag1, mag2;
    logic [DW-1:0]     acc_step, prod_fix;
    logic [XLEN-1:0]   div_sel, div_fix, calc_res;

    // One radix-2 step: shift-add multiply (LSB first) or restoring divide.
    // Multiply keeps {partial_hi, multiplier}; divide keeps {remainder, dividend/quotient}.
    function automatic logic [DW-1:0] step(input logic [DW-1:0] acc,
                                           input logic [XLEN-1:0] b,
                                           input logic is_div);
        logic [XLEN:0] sum;
        logic [XLEN:0] r;
        logic [XLEN:0] diff;
        sum  = {1'b0, acc[DW-1:XLEN]} + (acc[0] ? {1'b0, b} : '0);
        r    = acc[DW-1:XLEN-1];
        diff = r - {1'b0, b};
        if (!is_div)
            step = {sum, acc[XLEN-1:1]};
        else if (!diff[XLEN])
            step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            step = {r[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    endfunction

    // Operand signedness, magnitudes and special-case detection for the incoming op.
    always_comb begin
        s1_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
        s2_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        s1_neg    = s1_signed && src1_i[XLEN-1];
        s2_neg    = s2_signed && src2_i[XLEN-1];
        mag1      = s1_neg ? (-src1_i) : src1_i;
        mag2      = s2_neg ? (-src2_i) : src2_i;
        is_div_i  = op_i[2];
        div_ovf   = ((op_i == OP_DIV) || (op_i == OP_REM))
                    && (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (src2_i == '1);
    end

    // Iteration datapath and final-cycle sign correction.
    always_comb begin
        acc_step = acc_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            acc_step = step(acc_step, opb_q, op_q[2]);
        end
        prod_fix = neg_q ? (-acc_step) : acc_step;
        div_sel  = op_q[1] ? acc_step[DW-1:XLEN] : acc_step[XLEN-1:0];
        div_fix  = neg_q ? (-div_sel) : div_sel;
        if (op_q[2])
            calc_res = div_fix;
        else if (op_q == OP_MUL)
            calc_res = prod_fix[XLEN-1:0];
        else
            calc_res = prod_fix[DW-1:XLEN];
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_prod;
    logic [XLEN-1:0]          fast_res;

    // Single-cycle signed 33x33 product; sign extension encodes operand signedness.
    always_comb begin
        fast_a    = signed'({s1_signed & src1_i[XLEN-1], src1_i});
        fast_b    = signed'({s2_signed & src2_i[XLEN-1], src2_i});
        fast_prod = fast_a * fast_b;
        fast_res  = (op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[DW-1:XLEN];
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dest_d   = dest_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        done_d   = done_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (start_i && !squash_i) begin
                    op_d    = op_i;
                    dest_d  = dest_i;
                    cnt_d   = '0;
                    neg_d   = (op_i == OP_REM) ? s1_neg : (s1_neg ^ s2_neg);
                    acc_d   = {{XLEN{1'b0}}, (is_div_i ? mag1 : mag2)};
                    opb_d   = is_div_i ? mag2 : mag1;
                    state_d = S_CALC;
                    if (is_div_i && (src2_i == '0)) begin
                        result_d = op_i[1] ? src1_i : '1;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div_i) begin
                        result_d = fast_res;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                if (squash_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(CALC_LEN - 1)) begin
                    result_d = calc_res;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (squash_i || !hold_i) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            dest_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dest_q   <= dest_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Stall holds IF/ID and ID/EX while an op is being accepted or iterating.
    always_comb begin
        stall_o = rst_n && (((state_q == S_IDLE) && start_i) || (state_q == S_CALC));
    end

    assign done_o   = done_q;
    assign result_o = result_q;
    assign dest_o   = dest_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected results, a monitor
// compares every DONE cycle against the head of the queue.
module tb_ex_muldiv;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
    localparam int DIV_LAT = 33;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dest;
        int          cyc;
        int          id;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  dest_i;
    logic        squash_i;
    logic        hold_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  dest_o;

    exp_t sb[$];
    int   compared = 0;
    int   failed   = 0;
    int   cyc      = 0;
    int   test_id  = 0;
    logic prev_done = 1'b0;

    ex_muldiv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .dest_i   (dest_i),
        .squash_i (squash_i),
        .hold_i   (hold_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .dest_o   (dest_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s (test %0d): got 0x%08h, expected 0x%08h", nm, id, got, exp);
        end
    endtask

    // Monitor: checks each DONE cycle; pops only when the result is accepted.
    always @(negedge clk) begin
        exp_t e;
        if (done_o) begin
            if (sb.size() == 0) begin
                compared++;
                failed++;
                $display("FAIL spurious_done: done_o=1 result=0x%08h dest=%0d, none expected", result_o, dest_o);
            end else begin
                e = sb[0];
                if (!prev_done) chk("latency_cycle", e.id, 32'(cyc), 32'(e.cyc));
                chk("result", e.id, result_o, e.res);
                chk("dest", e.id, 32'(dest_o), 32'(e.dest));
                if (!hold_i) void'(sb.pop_front());
            end
        end
        prev_done = done_o;
    end

    // Drive one op at posedge+1, count stall cycles, wait until its result is consumed.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [31:0] res, input int lat);
        int   n;
        int   w;
        exp_t e;
        op_i = op; src1_i = a; src2_i = b; dest_i = d; start_i = 1'b1;
        e.res = res; e.dest = d; e.cyc = cyc + lat; e.id = test_id;
        sb.push_back(e);
        n = 0;
        @(negedge clk);
        if (stall_o) n++;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (!stall_o) break;
            n++;
        end
        chk("stall_cycles", test_id, 32'(n), 32'(lat));
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (sb.size() != 0 && w < 200);
        if (sb.size() != 0) begin
            compared++;
            failed++;
            $display("FAIL done_timeout (test %0d): no done_o within 200 cycles", test_id);
            sb.delete();
        end
        test_id++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nd;
        rst_n = 1'b0; start_i = 1'b0; op_i = '0; src1_i = '0; src2_i = '0;
        dest_i = '0; squash_i = 1'b0; hold_i = 1'b0;
        #2;
        chk("reset_done", -1, 32'(done_o), 32'd0);
        chk("reset_result", -1, result_o, 32'd0);
        chk("reset_dest", -1, 32'(dest_o), 32'd0);
        chk("reset_stall", -1, 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Iterative divides and multiplies
        issue(DIVU,   32'd100,        32'd7,          5'd5,  32'd14,         DIV_LAT);
        issue(REMU,   32'd100,        32'd7,          5'd6,  32'd2,          DIV_LAT);
        issue(DIV,    32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  DIV_LAT);
        issue(REM,    32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  DIV_LAT);
        issue(DIV,    32'd20,         32'hFFFF_FFFD,  5'd10, 32'hFFFF_FFFA,  DIV_LAT);
        issue(REM,    32'd20,         32'hFFFF_FFFD,  5'd11, 32'd2,          DIV_LAT);
        issue(DIVU,   32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          DIV_LAT);
        issue(REMU,   32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  DIV_LAT);
        issue(MULH,   32'h8000_0000,  32'h8000_0000,  5'd14, 32'h4000_0000,  MUL_LAT);
        issue(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd15, 32'hFFFF_FFFF,  MUL_LAT);
        issue(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd16, 32'hFFFF_FFFE,  MUL_LAT);
        issue(MUL,    32'hFFFF_FFFD,  32'd5,          5'd17, 32'hFFFF_FFF1,  MUL_LAT);

        // Special cases resolve straight to DONE
        issue(DIV,    32'd5,          32'd0,          5'd18, 32'hFFFF_FFFF,  1);
        issue(REM,    32'd5,          32'd0,          5'd19, 32'd5,          1);
        issue(DIVU,   32'd5,          32'd0,          5'd20, 32'hFFFF_FFFF,  1);
        issue(REMU,   32'd5,          32'd0,          5'd21, 32'd5,          1);
        issue(DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd22, 32'h8000_0000,  1);
        issue(REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd23, 32'd0,          1);

        // Squash at CALC cycle 10: no result must ever appear
        op_i = DIVU; src1_i = 32'd1000; src2_i = 32'd3; dest_i = 5'd24; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        squash_i = 1'b1;
        @(posedge clk); #1;
        squash_i = 1'b0;
        @(negedge clk);
        chk("squash_stall", test_id, 32'(stall_o), 32'd0);
        chk("squash_done", test_id, 32'(done_o), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        test_id++;
        issue(MUL, 32'd3, 32'd4, 5'd25, 32'd12, MUL_LAT);

        // hold_i for 3 cycles in DONE keeps the result presented for 4 cycles
        op_i = DIV; src1_i = 32'd5; src2_i = 32'd0; dest_i = 5'd9; start_i = 1'b1;
        sb.push_back('{res: 32'hFFFF_FFFF, dest: 5'd9, cyc: cyc + 1, id: test_id});
        @(posedge clk); #1;
        start_i = 1'b0;
        hold_i  = 1'b1;
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_o) nd++;
            @(posedge clk); #1;
        end
        hold_i = 1'b0;
        @(negedge clk);
        if (done_o) nd++;
        @(posedge clk); #1;
        @(negedge clk);
        if (done_o) nd++;
        chk("hold_done_cycles", test_id, 32'(nd), 32'd4);
        chk("hold_queue_drained", test_id, 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        test_id++;

        // Asynchronous reset in the middle of an iterating op
        op_i = DIVU; src1_i = 32'd81; src2_i = 32'd9; dest_i = 5'd26; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_done", test_id, 32'(done_o), 32'd0);
        chk("async_rst_result", test_id, result_o, 32'd0);
        chk("async_rst_dest", test_id, 32'(dest_o), 32'd0);
        chk("async_rst_stall", test_id, 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        test_id++;

        issue(MUL, 32'd6, 32'd7, 5'd27, 32'd42, MUL_LAT);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
